// File: rtl/red_pitaya_mux_sched.sv
`default_nettype none
// ============================================================================
// Module      : red_pitaya_mux_sched
// Description : Round-robin sequencer for the FADS analog input multiplexer.
//               Steps the mux address through the enabled channels, blanks
//               the ADC for a settling time after every switch, integrates
//               ADC samples over a dwell window and hands each per-channel
//               sum downstream through a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module red_pitaya_mux_sched #(
  parameter int CHNL = 6,   // number of mux channels (1..8)
  parameter int DW   = 14,  // ADC sample width, signed
  parameter int TW   = 16,  // settle/dwell counter width
  parameter int SW   = 30   // result width (DW+TW)
) (
  input  logic            adc_clk_i,
  input  logic            adc_rstn_i,
  input  logic            enable_i,
  input  logic [CHNL-1:0] active_channels_i,
  input  logic [TW-1:0]   settle_i,
  input  logic [TW-1:0]   dwell_i,
  input  logic [DW-1:0]   adc_dat_i,
  input  logic            clr_i,
  output logic [2:0]      mux_addr_o,
  output logic            measuring_o,
  output logic [SW-1:0]   res_dat_o,
  output logic [2:0]      res_chan_o,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic            ovf_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SWITCH  = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_MEASURE = 2'd3
  } state_t;

  localparam logic [TW-1:0] c_one = {{(TW-1){1'b0}}, 1'b1};

  // Sequencer state
  state_t        state_q, state_d;
  logic          first_q, first_d;   // next SWITCH starts from channel 0
  logic [2:0]    addr_q, addr_d;
  logic [TW-1:0] dwell_q, dwell_d;   // dwell latched at SWITCH, already >= 1
  logic [TW-1:0] cnt_q, cnt_d;       // cycles remaining in SETTLE/MEASURE
  logic [SW-1:0] acc_q, acc_d;

  // Result holding register
  logic [SW-1:0] res_dat_q, res_dat_d;
  logic [2:0]    res_chan_q, res_chan_d;
  logic          res_valid_q, res_valid_d;
  logic          ovf_q, ovf_d;

  // Combinational helpers
  logic [SW-1:0] sample_sx;
  logic [TW-1:0] dwell_eff;
  logic [3:0]    search_start;
  logic          found_hi, found_lo;
  logic [2:0]    idx_hi, idx_lo;
  logic          next_found;
  logic [2:0]    next_chan;
  logic          new_result;
  logic          ovf_set;

  assign sample_sx = {{(SW-DW){adc_dat_i[DW-1]}}, adc_dat_i};
  assign dwell_eff = (dwell_i == '0) ? c_one : dwell_i;

  // Circular search for the next enabled channel: channels from search_start
  // upward win first, then the wrapped range 0..current (current last).
  always_comb begin
    search_start = 4'd0;
    if (!first_q) begin
      search_start = {1'b0, addr_q} + 4'd1;
    end
    if (search_start >= 4'(CHNL)) begin
      search_start = 4'd0;
    end
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = 3'd0;
    idx_lo   = 3'd0;
    // Walk downward so the lowest matching index is the one left standing.
    for (int i = CHNL - 1; i >= 0; i--) begin
      if (active_channels_i[i]) begin
        if (4'(i) >= search_start) begin
          found_hi = 1'b1;
          idx_hi   = 3'(i);
        end else begin
          found_lo = 1'b1;
          idx_lo   = 3'(i);
        end
      end
    end
    next_found = found_hi | found_lo;
    next_chan  = found_hi ? idx_hi : idx_lo;
  end

  // Next-state, counter and accumulator logic of the sequencer.
  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    addr_d     = addr_q;
    dwell_d    = dwell_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    res_dat_d  = res_dat_q;
    res_chan_d = res_chan_q;
    new_result = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable_i && (|active_channels_i)) begin
          state_d = ST_SWITCH;
          first_d = 1'b1;
        end
      end

      ST_SWITCH: begin
        first_d = 1'b0;
        if (!enable_i || !next_found) begin
          // Abort or empty mask: park with the address unchanged.
          state_d = ST_IDLE;
          cnt_d   = '0;
          acc_d   = '0;
        end else begin
          addr_d  = next_chan;
          dwell_d = dwell_eff;
          acc_d   = '0;
          if (settle_i != '0) begin
            state_d = ST_SETTLE;
            cnt_d   = settle_i - c_one;
          end else begin
            state_d = ST_MEASURE;
            cnt_d   = dwell_eff - c_one;
          end
        end
      end

      ST_SETTLE: begin
        if (!enable_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          acc_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_MEASURE;
          cnt_d   = dwell_q - c_one;
          acc_d   = '0;
        end else begin
          cnt_d = cnt_q - c_one;
        end
      end

      ST_MEASURE: begin
        if (!enable_i) begin
          // Partial sum is thrown away; no result is produced.
          state_d = ST_IDLE;
          cnt_d   = '0;
          acc_d   = '0;
        end else begin
          acc_d = acc_q + sample_sx;
          if (cnt_q == '0) begin
            new_result = 1'b1;
            res_dat_d  = acc_q + sample_sx;
            res_chan_d = addr_q;
            state_d    = ST_SWITCH;
          end else begin
            cnt_d = cnt_q - c_one;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Result handshake and sticky overflow; a new overflow beats clr_i.
  always_comb begin
    res_valid_d = res_valid_q;
    ovf_set     = 1'b0;
    if (res_valid_q && res_ready_i) begin
      res_valid_d = 1'b0;
    end
    if (new_result) begin
      res_valid_d = 1'b1;
      if (res_valid_q && !res_ready_i) begin
        ovf_set = 1'b1;
      end
    end
    ovf_d = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (clr_i) begin
      ovf_d = 1'b0;
    end
  end

  // Sequencer state register.
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      state_q <= ST_IDLE;
      first_q <= 1'b0;
      addr_q  <= 3'd0;
      dwell_q <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      addr_q  <= addr_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  // Result register and flags.
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      res_dat_q   <= '0;
      res_chan_q  <= 3'd0;
      res_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      res_dat_q   <= res_dat_d;
      res_chan_q  <= res_chan_d;
      res_valid_q <= res_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign mux_addr_o  = addr_q;
  assign measuring_o = (state_q == ST_MEASURE);
  assign busy_o      = (state_q != ST_IDLE);
  assign res_dat_o   = res_dat_q;
  assign res_chan_o  = res_chan_q;
  assign res_valid_o = res_valid_q;
  assign ovf_o       = ovf_q;

endmodule
`default_nettype wire
